// File: rtl/pc_sequencer.sv
// Fetch-address controller: owns the PC, resolves branch/jump targets from decode,
// and sequences the one-cycle squash of the wrong-path instruction after a redirect.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        j_valid,
    input  logic [31:0] pc4,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] redirect_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        accept;

    // Requests are levels, not pulses: they are only looked at in an accepting
    // cycle (RUN, no stall); decode re-presents anything it held during a stall.
    always_comb begin
        br_target = pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        j_target  = {pc4[31:28], j_index, 2'b00};
        accept    = (state_q == RUN) && !stall && (j_valid || (br_valid && br_taken));

        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (accept) begin
                    pc_d    = j_valid ? j_target : br_target;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = FLUSH;
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FLUSH: begin
                // Decode holds the squashed wrong-path instruction, so requests are ignored.
                state_d = RUN;
                if (!stall) pc_d = pc_q + 32'd4;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign redirect_cnt = cnt_q;
    assign flush        = (state_q == FLUSH);
    assign fetch_valid  = (state_q != BOOT) && !stall;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, branch/jump targets, priority, stall,
// squash sequencing, PC wrap and reset during the flush cycle.
module tb_pc_sequencer;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        j_valid;
    logic [31:0] pc4;
    logic [15:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic [15:0] redirect_cnt;
    logic [1:0]  dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0040)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .j_valid      (j_valid),
        .pc4          (pc4),
        .br_imm       (br_imm),
        .j_index      (j_index),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .redirect_cnt (redirect_cnt),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        br_valid = 1'b0;
        br_taken = 1'b0;
        j_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        stall = 1'b0;
        clear_req();
        pc4 = '0;
        br_imm = '0;
        j_index = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 32'h40) $display("FAIL boot_pc: got %h want %h", pc, 32'h40); else pass_cnt++;
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL boot_fetch_valid: got %b want 0", fetch_valid); else pass_cnt++;
        total_cnt++;
        if (dbg_state !== S_BOOT) $display("FAIL boot_state: got %0d want %0d", dbg_state, S_BOOT); else pass_cnt++;
        total_cnt++;
        if (flush !== 1'b0 || redirect_cnt !== 16'd0)
            $display("FAIL boot_flush_cnt: got %b/%0d want 0/0", flush, redirect_cnt);
        else pass_cnt++;
    endtask

    task automatic test_run;
        logic [31:0] exp_pc;
        exp_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (pc !== exp_pc || fetch_valid !== 1'b1)
                $display("FAIL run_seq%0d: got pc=%h fv=%b want pc=%h fv=1", i, pc, fetch_valid, exp_pc);
            else pass_cnt++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backward_branch;
        br_valid = 1'b1; br_taken = 1'b1; pc4 = 32'h100; br_imm = 16'hFFFF;
        tick();
        clear_req();
        total_cnt++;
        if (pc !== 32'hFC || flush !== 1'b1 || redirect_cnt !== 16'd1)
            $display("FAIL bwd_branch: got pc=%h fl=%b cnt=%0d want pc=000000fc fl=1 cnt=1", pc, flush, redirect_cnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pc !== 32'h100 || flush !== 1'b0)
            $display("FAIL bwd_after: got pc=%h fl=%b want pc=00000100 fl=0", pc, flush);
        else pass_cnt++;
    endtask

    task automatic test_forward_and_not_taken;
        br_valid = 1'b1; br_taken = 1'b1; pc4 = 32'h100; br_imm = 16'h0FFF;
        tick();
        clear_req();
        total_cnt++;
        if (pc !== 32'h40FC || redirect_cnt !== 16'd2)
            $display("FAIL fwd_branch: got pc=%h cnt=%0d want pc=000040fc cnt=2", pc, redirect_cnt);
        else pass_cnt++;
        tick();
        br_valid = 1'b1; br_taken = 1'b0;
        tick();
        clear_req();
        total_cnt++;
        if (pc !== 32'h4104 || flush !== 1'b0 || redirect_cnt !== 16'd2)
            $display("FAIL not_taken: got pc=%h fl=%b cnt=%0d want pc=00004104 fl=0 cnt=2", pc, flush, redirect_cnt);
        else pass_cnt++;
    endtask

    task automatic test_jump_priority;
        j_valid = 1'b1; br_valid = 1'b1; br_taken = 1'b1;
        pc4 = 32'hA000_0010; j_index = 26'h3FF_FFFF; br_imm = 16'h0001;
        tick();
        clear_req();
        total_cnt++;
        if (pc !== 32'hAFFF_FFFC || flush !== 1'b1 || redirect_cnt !== 16'd3)
            $display("FAIL jump_prio: got pc=%h fl=%b cnt=%0d want pc=affffffc fl=1 cnt=3", pc, flush, redirect_cnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pc !== 32'hB000_0000 || dbg_state !== S_RUN)
            $display("FAIL jump_after: got pc=%h st=%0d want pc=b0000000 st=%0d", pc, dbg_state, S_RUN);
        else pass_cnt++;
    endtask

    task automatic test_stall;
        stall = 1'b1; br_valid = 1'b1; br_taken = 1'b1; pc4 = 32'h100; br_imm = 16'hFFFF;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL stall_fv: got %b want 0", fetch_valid); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (pc !== 32'hB000_0000 || flush !== 1'b0 || redirect_cnt !== 16'd3)
            $display("FAIL stall_hold: got pc=%h fl=%b cnt=%0d want pc=b0000000 fl=0 cnt=3", pc, flush, redirect_cnt);
        else pass_cnt++;
        stall = 1'b0;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b1) $display("FAIL unstall_fv: got %b want 1", fetch_valid); else pass_cnt++;
        tick();
        total_cnt++;
        if (pc !== 32'hFC || flush !== 1'b1 || redirect_cnt !== 16'd4)
            $display("FAIL stall_release: got pc=%h fl=%b cnt=%0d want pc=000000fc fl=1 cnt=4", pc, flush, redirect_cnt);
        else pass_cnt++;
        // Second request during FLUSH (jump added on top of held branch) must be dropped.
        j_valid = 1'b1; j_index = 26'h0000_123;
        tick();
        clear_req();
        total_cnt++;
        if (pc !== 32'h100 || flush !== 1'b0 || redirect_cnt !== 16'd4)
            $display("FAIL flush_drop: got pc=%h fl=%b cnt=%0d want pc=00000100 fl=0 cnt=4", pc, flush, redirect_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_flush_stall;
        j_valid = 1'b1; pc4 = 32'hF000_0000; j_index = 26'h3FF_FFFF;
        tick();
        clear_req();
        total_cnt++;
        if (pc !== 32'hFFFF_FFFC || flush !== 1'b1)
            $display("FAIL wrap_target: got pc=%h fl=%b want pc=fffffffc fl=1", pc, flush);
        else pass_cnt++;
        stall = 1'b1;
        tick();
        total_cnt++;
        if (pc !== 32'hFFFF_FFFC || flush !== 1'b0 || dbg_state !== S_RUN)
            $display("FAIL flush_stall: got pc=%h fl=%b st=%0d want pc=fffffffc fl=0 st=%0d", pc, flush, dbg_state, S_RUN);
        else pass_cnt++;
        stall = 1'b0;
        tick();
        total_cnt++;
        if (pc !== 32'h0000_0000) $display("FAIL pc_wrap: got %h want 00000000", pc); else pass_cnt++;
    endtask

    task automatic test_reset_in_flush;
        j_valid = 1'b1; pc4 = 32'h1000_0000; j_index = 26'h0000_400;
        tick();
        clear_req();
        total_cnt++;
        if (dbg_state !== S_FLUSH || pc !== 32'h1000_1000 || redirect_cnt !== 16'd6)
            $display("FAIL pre_reset: got st=%0d pc=%h cnt=%0d want st=%0d pc=10001000 cnt=6",
                     dbg_state, pc, redirect_cnt, S_FLUSH);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 32'h40 || dbg_state !== S_BOOT || flush !== 1'b0 || redirect_cnt !== 16'd0 || fetch_valid !== 1'b0)
            $display("FAIL reset_in_flush: got pc=%h st=%0d fl=%b cnt=%0d fv=%b want pc=00000040 st=0 fl=0 cnt=0 fv=0",
                     pc, dbg_state, flush, redirect_cnt, fetch_valid);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (pc !== 32'h44) $display("FAIL post_reset_run: got %h want 00000044", pc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_backward_branch();
        test_forward_and_not_taken();
        test_jump_priority();
        test_stall();
        test_wrap_and_flush_stall();
        test_reset_in_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-address controller for the single-issue CPU. It owns the program counter and advances it by 4 each cycle. It computes branch and jump targets from the decode stage, applying sign extension and the word-offset left shift by 2. It sequences the one-cycle squash of the wrong-path instruction after a redirect. It sits between the hazard unit (stall), the decode stage (branch/jump requests) and instruction memory (fetch address).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hazard-unit hold. PC and requests frozen while high.
- br_valid  in  1  a conditional branch is in decode.
- br_taken  in  1  branch condition result; meaningful only with br_valid.
- j_valid  in  1  an unconditional jump is in decode.
- pc4  in  32  PC+4 of the decode-stage instruction.
- br_imm  in  16  branch word offset, two's complement.
- j_index  in  26  jump word index.
- pc  out  32  current fetch address (registered).
- fetch_valid  out  1  the instruction fetched this cycle is to be kept.
- flush  out  1  squash the IF/ID register this cycle.
- redirect_cnt  out  16  count of accepted redirects, wraps at 2^16.

## Operation
- Branch target is pc4 + { {14{br_imm[15]}}, br_imm, 2'b00 }, modulo 2^32; carry out is discarded.
- Jump target is { pc4[31:28], j_index, 2'b00 }.
- Targets are always word aligned, so pc[1:0] is always 00 when RESET_PC[1:0]=00.
- Sequential PC is pc + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- A redirect is accepted in a cycle when all of the following hold:
  - state = RUN;
  - stall = 0;
  - (j_valid = 1) or (br_valid = 1 and br_taken = 1).
- Priority when both request types are present: j_valid beats br_valid, and the jump target is used.
- br_valid with br_taken = 0 is not a redirect; the PC advances sequentially.
- Requests are levels, not pulses. They are sampled only in accepting cycles, and a request present during stall is re-presented by decode after the stall.
- State machine, 3 states:
  - BOOT: entered on reset. fetch_valid=0, flush=0. Unconditionally goes to RUN next cycle; pc holds RESET_PC.
  - RUN: if stall=1, pc holds. Else if a redirect is accepted, pc <= target, redirect_cnt <= redirect_cnt+1, go to FLUSH. Else pc <= pc+4.
  - FLUSH: flush=1 for exactly one cycle, then return to RUN regardless of stall. All requests are ignored, because the decode instruction is the squashed wrong-path one. pc <= pc+4 if stall=0, otherwise pc holds.
- Outputs:
  - fetch_valid = (state != BOOT) and (stall = 0).
  - flush = (state = FLUSH).
- Reset values: pc=RESET_PC, state=BOOT, redirect_cnt=0, flush=0, fetch_valid=0.

## Timing
- Redirect latency: a request accepted in cycle N puts the target on pc in cycle N+1, with flush=1 in cycle N+1.
- The first sequential step after the target is pc = target+4 in cycle N+2 if not stalled.
- Exactly one wrong-path instruction is fetched per redirect: the one at pc in cycle N. No delay slot is honoured.
- Back-to-back redirects: a request in FLUSH is dropped. The earliest next accepted redirect is cycle N+2.
- Stall in the accepting cycle: no redirect, and pc holds. Stall during FLUSH: pc holds, flush still pulses once, and the state returns to RUN.
- Reset mid-operation (any state, including FLUSH or stall) takes effect at the next edge. In-flight redirects are lost, and redirect_cnt clears.
- No combinational path from inputs to pc. fetch_valid is combinational from stall only.

## Test plan
- Reset then run: rst held 2 cycles, RESET_PC=0x0000_0040, no requests.
  - Required: BOOT cycle shows pc=0x40, fetch_valid=0.
  - Then pc=0x40, 0x44, 0x48 in successive cycles with fetch_valid=1.
- Backward branch: in RUN, br_valid=1, br_taken=1, pc4=0x0000_0100, br_imm=0xFFFF.
  - Required: next cycle pc=0x0000_00FC, flush=1, redirect_cnt=1.
  - Following cycle pc=0x0000_0100, flush=0.
- Forward branch and not-taken: pc4=0x0000_0100, br_imm=0x0FFF, taken.
  - Required: pc=0x0000_40FC.
  - The same request with br_taken=0 gives pc+4, flush=0, and redirect_cnt unchanged.
- Jump priority and region bits: j_valid=1 and br_valid=1, br_taken=1, pc4=0xA000_0010, j_index=0x3FF_FFFF, br_imm=0x0001.
  - Required: pc=0xAFFF_FFFC (the jump wins).
- Stall interaction: stall=1 for 3 cycles with br_valid=1, br_taken=1 held.
  - Required: pc frozen, fetch_valid=0, no redirect.
  - On the first stall=0 cycle the redirect is accepted.
  - A second request asserted during the FLUSH cycle is ignored.
- Wrap and reset mid-FLUSH:
  - pc=0xFFFF_FFFC in RUN gives pc=0x0000_0000 next cycle.
  - Asserting rst during FLUSH gives pc=RESET_PC, state=BOOT, flush=0 and redirect_cnt=0 next cycle.
